dcache_ctrl: RTL

Direct-mapped, write-through, read-allocate data-cache controller that sits directly upstream of the dcache data and tag memory arrays. It accepts CPU load/store requests and drives the data-array and tag-array ports, which have 1-cycle synchronous read latency. It holds per-line valid bits in flops. On a read miss it refills a whole line from the memory bus. The top-level dcache wrapper instantiates this controller beside the two arrays.

---
 rtl/dcache_pkg.sv | 54 +++++
 rtl/dcache_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/dcache_pkg.sv
// Shared types and address helpers for the direct-mapped data-cache controller.
package dcache_pkg;

  localparam int unsigned CPU_ADDR_W = 32;
  localparam int unsigned CPU_DATA_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WR_MEM,
    RF_REQ,
    RF_DATA,
    RESP
  } dcache_state_e;

  typedef struct packed {
    logic                  we;
    logic [CPU_ADDR_W-1:0] addr;
    logic [CPU_DATA_W-1:0] wdata;
  } cpu_req_t;

  function automatic int unsigned wo_w(input int unsigned words_per_line);
    return $clog2(words_per_line);
  endfunction

  function automatic int unsigned idx_w(input int unsigned num_lines);
    return $clog2(num_lines);
  endfunction

  function automatic int unsigned tag_w(input int unsigned addr_w,
                                        input int unsigned num_lines,
                                        input int unsigned words_per_line);
    return addr_w - 2 - wo_w(words_per_line) - idx_w(num_lines);
  endfunction

  // Field extractors return right-justified fields; callers truncate to width.
  function automatic logic [CPU_ADDR_W-1:0] addr_word(input logic [CPU_ADDR_W-1:0] addr,
                                                      input int unsigned           wo_bits);
    return (addr >> 2) & ((CPU_ADDR_W'(1) << wo_bits) - CPU_ADDR_W'(1));
  endfunction

  function automatic logic [CPU_ADDR_W-1:0] addr_index(input logic [CPU_ADDR_W-1:0] addr,
                                                       input int unsigned           wo_bits,
                                                       input int unsigned           idx_bits);
    return (addr >> (2 + wo_bits)) & ((CPU_ADDR_W'(1) << idx_bits) - CPU_ADDR_W'(1));
  endfunction

  function automatic logic [CPU_ADDR_W-1:0] addr_tag(input logic [CPU_ADDR_W-1:0] addr,
                                                     input int unsigned           wo_bits,
                                                     input int unsigned           idx_bits);
    return addr >> (2 + wo_bits + idx_bits);
  endfunction

endpackage

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, read-allocate data-cache controller.
// Drives external data/tag arrays (1-cycle synchronous read) and a memory bus.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int unsigned ADDR_W         = CPU_ADDR_W,
  parameter int unsigned DATA_W         = CPU_DATA_W,
  parameter int unsigned NUM_LINES      = 64,
  parameter int unsigned WORDS_PER_LINE = 4,
  localparam int unsigned WO_W          = wo_w(WORDS_PER_LINE),
  localparam int unsigned IDX_W         = idx_w(NUM_LINES),
  localparam int unsigned TAG_W         = tag_w(ADDR_W, NUM_LINES, WORDS_PER_LINE),
  localparam int unsigned DMEM_AW       = IDX_W + WO_W + 1,
  localparam int unsigned TMEM_AW       = IDX_W + 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  input  logic               cpu_req_valid_i,
  output logic               cpu_req_ready_o,
  input  logic               cpu_req_we_i,
  input  logic [ADDR_W-1:0]  cpu_req_addr_i,
  input  logic [DATA_W-1:0]  cpu_req_wdata_i,
  output logic               cpu_rsp_valid_o,
  output logic [DATA_W-1:0]  cpu_rsp_rdata_o,
  output logic               mem_req_valid_o,
  input  logic               mem_req_ready_i,
  output logic               mem_req_we_o,
  output logic [ADDR_W-1:0]  mem_req_addr_o,
  output logic [DATA_W-1:0]  mem_req_wdata_o,
  input  logic               mem_rsp_valid_i,
  input  logic [DATA_W-1:0]  mem_rsp_rdata_i,
  output logic               dmem_ceb_o,
  output logic               dmem_ren_o,
  output logic               dmem_wen_o,
  output logic [DMEM_AW-1:0] dmem_addr_o,
  output logic [DATA_W-1:0]  dmem_wdata_o,
  input  logic [DATA_W-1:0]  dmem_rdata_i,
  output logic               tmem_ceb_o,
  output logic               tmem_ren_o,
  output logic               tmem_wen_o,
  output logic [TMEM_AW-1:0] tmem_addr_o,
  output logic [TAG_W-1:0]   tmem_wdata_o,
  input  logic [TAG_W-1:0]   tmem_rdata_i
);

  dcache_state_e        state_q;
  logic                 init_q;
  logic [NUM_LINES-1:0] valid_q;
  logic [WO_W-1:0]      beat_q;
  cpu_req_t             req_q;
  logic [DATA_W-1:0]    rsp_q;

  logic [IDX_W-1:0]     in_idx, idx_q;
  logic [WO_W-1:0]      in_word, word_q;
  logic [TAG_W-1:0]     tag_q;
  logic                 accept, hit, last_beat;

  assign in_idx  = IDX_W'(addr_index(cpu_req_addr_i, WO_W, IDX_W));
  assign in_word = WO_W'(addr_word(cpu_req_addr_i, WO_W));
  assign idx_q   = IDX_W'(addr_index(req_q.addr, WO_W, IDX_W));
  assign word_q  = WO_W'(addr_word(req_q.addr, WO_W));
  assign tag_q   = TAG_W'(addr_tag(req_q.addr, WO_W, IDX_W));

  assign cpu_req_ready_o = init_q & (state_q == IDLE) & ~flush_i;
  assign accept          = cpu_req_valid_i & cpu_req_ready_o;
  assign hit             = valid_q[idx_q] & (tmem_rdata_i == tag_q);
  assign last_beat       = (beat_q == '1);

  // Controller state, valid bits, latched request and refill capture.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      init_q  <= 1'b0;
      valid_q <= '0;
      beat_q  <= '0;
      req_q   <= '0;
      rsp_q   <= '0;
    end else begin
      init_q <= 1'b1;
      unique case (state_q)
        IDLE: begin
          if (flush_i) begin
            valid_q <= '0;
          end else if (accept) begin
            req_q   <= '{we: cpu_req_we_i, addr: cpu_req_addr_i, wdata: cpu_req_wdata_i};
            state_q <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (req_q.we)  state_q <= WR_MEM;
          else if (hit)  state_q <= IDLE;
          else           state_q <= RF_REQ;
        end
        WR_MEM: begin
          if (mem_req_ready_i) state_q <= IDLE;
        end
        RF_REQ: begin
          if (mem_req_ready_i) begin
            beat_q  <= '0;
            state_q <= RF_DATA;
          end
        end
        RF_DATA: begin
          if (mem_rsp_valid_i) begin
            beat_q <= beat_q + 1'b1;
            if (beat_q == word_q) rsp_q <= mem_rsp_rdata_i;
            if (last_beat) begin
              valid_q[idx_q] <= 1'b1;
              state_q        <= RESP;
            end
          end
        end
        RESP: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Per-state decode of CPU response, memory bus and array port controls.
  always_comb begin
    cpu_rsp_valid_o = 1'b0;
    cpu_rsp_rdata_o = '0;
    mem_req_valid_o = 1'b0;
    mem_req_we_o    = 1'b0;
    mem_req_addr_o  = '0;
    mem_req_wdata_o = '0;
    dmem_ren_o      = 1'b0;
    dmem_wen_o      = 1'b0;
    dmem_addr_o     = '0;
    dmem_wdata_o    = '0;
    tmem_ren_o      = 1'b0;
    tmem_wen_o      = 1'b0;
    tmem_addr_o     = '0;
    tmem_wdata_o    = '0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          dmem_ren_o  = 1'b1;
          dmem_addr_o = {1'b0, in_idx, in_word};
          tmem_ren_o  = 1'b1;
          tmem_addr_o = {1'b0, in_idx};
        end
      end
      LOOKUP: begin
        if (req_q.we) begin
          if (hit) begin
            dmem_wen_o   = 1'b1;
            dmem_addr_o  = {1'b0, idx_q, word_q};
            dmem_wdata_o = req_q.wdata;
          end
        end else if (hit) begin
          cpu_rsp_valid_o = 1'b1;
          cpu_rsp_rdata_o = dmem_rdata_i;
        end
      end
      WR_MEM: begin
        mem_req_valid_o = 1'b1;
        mem_req_we_o    = 1'b1;
        mem_req_addr_o  = req_q.addr;
        mem_req_wdata_o = req_q.wdata;
        cpu_rsp_valid_o = mem_req_ready_i;
      end
      RF_REQ: begin
        mem_req_valid_o = 1'b1;
        mem_req_addr_o  = {tag_q, idx_q, {WO_W{1'b0}}, 2'b00};
      end
      RF_DATA: begin
        if (mem_rsp_valid_i) begin
          dmem_wen_o   = 1'b1;
          dmem_addr_o  = {1'b0, idx_q, beat_q};
          dmem_wdata_o = mem_rsp_rdata_i;
          if (last_beat) begin
            tmem_wen_o   = 1'b1;
            tmem_addr_o  = {1'b0, idx_q};
            tmem_wdata_o = tag_q;
          end
        end
      end
      RESP: begin
        cpu_rsp_valid_o = 1'b1;
        cpu_rsp_rdata_o = rsp_q;
      end
      default: ;
    endcase
  end

  assign dmem_ceb_o = dmem_ren_o | dmem_wen_o;
  assign tmem_ceb_o = tmem_ren_o | tmem_wen_o;

endmodule
